arb_mux_reg: RTL and testbench
==============================

Name: arb_mux_reg

Overview:
- Parametrised N-channel, W-bit selector, generalising the fixed 4:1 32-bit datapath mux.
- Adds per-channel valid/ready handshakes and three selection modes: external select, fixed priority, round-robin.
- Adds a registered output stage, so there is one cycle of latency at full throughput.
- Used where several pipeline sources share one sink, e.g. IF and MEM requests to a single memory port, or multi-source writeback.

Parameters:
- WIDTH, 32, data width per channel.
- NCH, 4, number of input channels (2..16).
- SELW, $clog2(NCH), width of the select and channel-ID fields (derived; do not override).
- MODE, 0, selection mode: 0 = external sel, 1 = fixed priority (lowest index wins), 2 = round-robin.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_data  in  NCH*WIDTH  packed channel data; channel i occupies [i*WIDTH +: WIDTH].
- in_valid  in  NCH  per-channel valid.
- in_ready  out  NCH  per-channel ready.
- sel  in  SELW  channel select; used only when MODE=0.
- out_data  out  WIDTH  registered selected data.
- out_valid  out  1  output holds a word.
- out_ready  in  1  sink accepts the word.
- out_ch  out  SELW  index of the channel that produced out_data.

Behaviour:
- Reset (async assert, sync release): out_valid=0, out_data=0, out_ch=0, round-robin pointer rr_ptr=0. in_ready is combinational and is 0 while out_valid=0 only if no channel is granted.
- load = !out_valid || out_ready. The output register accepts a new word whenever it is empty or is draining in the same cycle.
- grant (one-hot or zero, combinational from in_valid, sel, rr_ptr):
  - MODE 0: grant[sel]=in_valid[sel]. If sel>=NCH, no grant. Other channels always stall.
  - MODE 1: lowest-index i with in_valid[i]=1.
  - MODE 2: first i with in_valid[i]=1, searching rr_ptr, rr_ptr+1, ... modulo NCH.
- in_ready[i] = grant[i] && load. At most one in_ready is high per cycle, and it never depends on in_valid of the same channel except through grant.
- Transfer on channel g when in_valid[g] && in_ready[g]. At the next edge: out_data <= in_data[g], out_ch <= g, out_valid <= 1.
- If load=1 and there is no transfer, out_valid <= 0 at the next edge (drain). If load=0, all output registers hold.
- Simultaneous drain and fill: out_ready=1 with a new transfer in the same cycle gives back-to-back output with no bubble, one word per cycle sustained.
- Latency: exactly 1 cycle from input transfer to out_valid.
- rr_ptr (MODE 2 only) updates on transfer: rr_ptr <= (g==NCH-1) ? 0 : g+1. It holds otherwise. In MODE 0 and 1, rr_ptr stays 0.
- Stability: when out_valid=1 and out_ready=0, out_data and out_ch must not change.
- Inputs may change freely while not granted. The source must keep in_data stable only while in_valid=1 and not yet accepted.
- Fairness (MODE 2): with all channels valid continuously, grants rotate 0,1,..,NCH-1,0,...
- Reset mid-operation: any word in the output register is discarded immediately (out_valid drops asynchronously) and rr_ptr returns to 0.
- MODE must be checked by an elaboration-time assertion to be in 0..2, and NCH in 2..16.

Decomposition:
- Shared package (cpu_pkg): mode constants ARB_SEL=0, ARB_PRIO=1, ARB_RR=2, plus the $clog2-based width helper.
- One sub-module, arb_rr_grant: combinational priority and round-robin grant from (req, ptr, mode), parametrised by NCH. It is reused by the future bus arbiter.
- The output register and handshake stay in arb_mux_reg.

Test Plan:
- Reset: hold rst_n=0 with in_valid=4'hF -> out_valid=0, out_data=0, out_ch=0. Deassert rst_n; first accepted word appears exactly 1 cycle after the transfer.
- MODE 0, sel=2, in_valid=4'b0101, ch2 data=32'hCAFE0002, out_ready=1 -> in_ready=4'b0100; next cycle out_data=32'hCAFE0002, out_ch=2. Set sel=1 (ch1 invalid) -> in_ready=0, and out_valid drops the cycle after.
- MODE 1, in_valid=4'b1010 for 3 cycles, out_ready=1 -> ch1 granted every cycle, out_ch=1 ×3; ch3 starved.
- MODE 2, in_valid=4'hF held 8 cycles, out_ready=1 -> out_ch sequence 0,1,2,3,0,1,2,3, no bubbles. Then in_valid=4'b1001 -> alternates 3,0 (pointer wraps correctly).
- Backpressure: out_valid=1, out_ready=0 for 5 cycles with a changing in_data -> out_data/out_ch stable and in_ready=0. Raise out_ready with a valid pending -> drain and refill in the same cycle, no gap.
- Async reset mid-stream in MODE 2 after grants 0,1 -> out_valid drops immediately. After release with in_valid=4'hF, the first grant is ch0.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared arbitration constants and the select/channel-ID width helper.
package cpu_pkg;

   localparam logic [1:0] ARB_SEL  = 2'd0;
   localparam logic [1:0] ARB_PRIO = 2'd1;
   localparam logic [1:0] ARB_RR   = 2'd2;

   function automatic int idx_width(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/arb_rr_grant.sv
// Combinational grant: external select, fixed priority or round-robin from ptr.
module arb_rr_grant
   import cpu_pkg::*;
#(
   parameter int NCH  = 4,
   parameter int SELW = idx_width(NCH)
) (
   input  logic [NCH-1:0]  req_i,
   input  logic [SELW-1:0] ptr_i,
   input  logic [1:0]      mode_i,
   output logic [NCH-1:0]  grant_o,
   output logic [SELW-1:0] idx_o,
   output logic            vld_o
);

   logic [SELW-1:0] start;
   logic [SELW-1:0] cand;
   int              pos;

   // Fixed priority is round-robin with the search anchored at channel 0.
   assign start = (mode_i == ARB_RR) ? ptr_i : '0;

   always_comb begin
      vld_o = 1'b0;
      idx_o = '0;
      cand  = '0;
      pos   = 0;
      if (mode_i == ARB_SEL) begin
         if ((int'(ptr_i) < NCH) && req_i[ptr_i]) begin
            vld_o = 1'b1;
            idx_o = ptr_i;
         end
      end else begin
         for (int k = 0; k < NCH; k++) begin
            pos = int'(start) + k;
            if (pos >= NCH) pos = pos - NCH;
            cand = SELW'(pos);
            if (!vld_o && req_i[cand]) begin
               vld_o = 1'b1;
               idx_o = cand;
            end
         end
      end
   end

   assign grant_o = vld_o ? (NCH'(1) << idx_o) : '0;

endmodule

// File: rtl/arb_mux_reg.sv
// N-channel valid/ready selector with a registered output stage (1-cycle latency,
// full throughput). Selection by external sel, fixed priority or round-robin.
module arb_mux_reg
   import cpu_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int NCH   = 4,
   parameter int SELW  = idx_width(NCH),
   parameter int MODE  = 0
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [NCH*WIDTH-1:0] in_data,
   input  logic [NCH-1:0]       in_valid,
   output logic [NCH-1:0]       in_ready,
   input  logic [SELW-1:0]      sel,
   output logic [WIDTH-1:0]     out_data,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [SELW-1:0]      out_ch
);

   localparam logic [1:0] MODE_W = 2'(MODE);

   if (MODE < 0 || MODE > 2) begin : g_bad_mode
      $error("arb_mux_reg: MODE must be 0..2");
   end
   if (NCH < 2 || NCH > 16) begin : g_bad_nch
      $error("arb_mux_reg: NCH must be 2..16");
   end

   logic [NCH-1:0]   grant;
   logic [SELW-1:0]  gnt_idx;
   logic             gnt_vld;
   logic [SELW-1:0]  ptr_in;
   logic             load;
   logic             xfer;
   logic [WIDTH-1:0] gnt_data;

   logic [WIDTH-1:0] out_data_q,  out_data_d;
   logic [SELW-1:0]  out_ch_q,    out_ch_d;
   logic             out_valid_q, out_valid_d;
   logic [SELW-1:0]  rr_ptr_q,    rr_ptr_d;

   assign ptr_in = (MODE_W == ARB_SEL) ? sel : rr_ptr_q;

   arb_rr_grant #(
      .NCH  (NCH),
      .SELW (SELW)
   ) u_grant (
      .req_i   (in_valid),
      .ptr_i   (ptr_in),
      .mode_i  (MODE_W),
      .grant_o (grant),
      .idx_o   (gnt_idx),
      .vld_o   (gnt_vld)
   );

   // Register takes a word when empty or draining this cycle.
   assign load     = !out_valid_q || out_ready;
   assign in_ready = grant & {NCH{load}};
   assign xfer     = gnt_vld && load;

   always_comb begin
      gnt_data = '0;
      for (int i = 0; i < NCH; i++) begin
         if (grant[i]) gnt_data = in_data[i*WIDTH +: WIDTH];
      end
   end

   always_comb begin
      out_data_d  = out_data_q;
      out_ch_d    = out_ch_q;
      out_valid_d = out_valid_q;
      rr_ptr_d    = rr_ptr_q;
      if (load) begin
         out_valid_d = xfer;
         if (xfer) begin
            out_data_d = gnt_data;
            out_ch_d   = gnt_idx;
         end
      end
      if (xfer && (MODE_W == ARB_RR)) begin
         rr_ptr_d = (gnt_idx == SELW'(NCH-1)) ? '0 : SELW'(gnt_idx + 1'b1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_data_q  <= '0;
         out_ch_q    <= '0;
         out_valid_q <= 1'b0;
         rr_ptr_q    <= '0;
      end else begin
         out_data_q  <= out_data_d;
         out_ch_q    <= out_ch_d;
         out_valid_q <= out_valid_d;
         rr_ptr_q    <= rr_ptr_d;
      end
   end

   assign out_data  = out_data_q;
   assign out_ch    = out_ch_q;
   assign out_valid = out_valid_q;

endmodule

// File: tb/tb_arb_mux_reg.sv
// Bench for arb_mux_reg: one instance per MODE on shared stimulus, a queue-free
// behavioural model checked every cycle, plus directed literal expectations.
module tb_arb_mux_reg;

   logic          clk;
   logic          rst_n;
   logic [127:0]  in_data;
   logic [3:0]    in_valid;
   logic [1:0]    sel;
   logic          out_ready;

   logic [3:0]    rdy_w  [3];
   logic [31:0]   data_w [3];
   logic          vld_w  [3];
   logic [1:0]    ch_w   [3];

   int errors = 0;
   int checks = 0;

   for (genvar m = 0; m < 3; m++) begin : g_dut
      arb_mux_reg #(
         .WIDTH (32),
         .NCH   (4),
         .MODE  (m)
      ) u_dut (
         .clk       (clk),
         .rst_n     (rst_n),
         .in_data   (in_data),
         .in_valid  (in_valid),
         .in_ready  (rdy_w[m]),
         .sel       (sel),
         .out_data  (data_w[m]),
         .out_valid (vld_w[m]),
         .out_ready (out_ready),
         .out_ch    (ch_w[m])
      );
   end

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic set_data(input logic [31:0] base);
      for (int i = 0; i < 4; i++) in_data[i*32 +: 32] = base + 32'(i);
   endtask

   // Which channel the rules pick, or -1.
   function automatic int mgrant(input int mode, input logic [3:0] v, input int s, input int p);
      if (mode == 0) return (s < 4 && v[s]) ? s : -1;
      for (int k = 0; k < 4; k++) begin
         int c;
         c = (mode == 1) ? k : (p + k) % 4;
         if (v[c]) return c;
      end
      return -1;
   endfunction

   // Model state: output word held, its channel, and round-robin start point.
   logic        mv [3];
   logic [31:0] md [3];
   int          mc [3];
   int          mp [3];
   int          g_m;
   logic        ld_m;
   logic [3:0]  er_m;

   initial begin
      for (int m = 0; m < 3; m++) begin
         mv[m] = 1'b0; md[m] = '0; mc[m] = 0; mp[m] = 0;
      end
   end

   always @(negedge clk) begin
      for (int m = 0; m < 3; m++) begin
         if (!rst_n) begin
            mv[m] = 1'b0; md[m] = '0; mc[m] = 0; mp[m] = 0;
         end
         ld_m = !mv[m] || out_ready;
         g_m  = mgrant(m, in_valid, int'(sel), mp[m]);
         er_m = (g_m >= 0 && ld_m) ? 4'(1 << g_m) : 4'b0;
         chk($sformatf("m%0d in_ready", m), 32'(rdy_w[m]), 32'(er_m));
         chk($sformatf("m%0d out_valid", m), 32'(vld_w[m]), 32'(mv[m]));
         if (mv[m] || !rst_n) begin
            chk($sformatf("m%0d out_data", m), data_w[m], md[m]);
            chk($sformatf("m%0d out_ch", m), 32'(ch_w[m]), 32'(mc[m]));
         end
         if (rst_n && ld_m) begin
            if (g_m >= 0) begin
               mv[m] = 1'b1;
               md[m] = in_data[g_m*32 +: 32];
               mc[m] = g_m;
               if (m == 2) mp[m] = (g_m + 1) % 4;
            end else begin
               mv[m] = 1'b0;
            end
         end
      end
   end

   initial begin
      logic [1:0] alt [4];
      alt[0] = 2'd0; alt[1] = 2'd3; alt[2] = 2'd0; alt[3] = 2'd3;

      rst_n = 1'b0; in_valid = 4'hF; out_ready = 1'b1; sel = 2'd0;
      set_data(32'hCAFE0000);
      repeat (3) @(posedge clk);
      #1;
      for (int m = 0; m < 3; m++) begin
         chk($sformatf("rst m%0d out_valid", m), 32'(vld_w[m]), 32'd0);
         chk($sformatf("rst m%0d out_data", m), data_w[m], 32'd0);
         chk($sformatf("rst m%0d out_ch", m), 32'(ch_w[m]), 32'd0);
      end
      rst_n = 1'b1;
      #1 chk("release out_valid", 32'(vld_w[1]), 32'd0);
      @(posedge clk); #1;
      chk("first word valid", 32'(vld_w[1]), 32'd1);
      chk("first word ch", 32'(ch_w[1]), 32'd0);
      chk("first word data", data_w[1], 32'hCAFE0000);

      // External select
      sel = 2'd2; in_valid = 4'b0101;
      #1 chk("sel2 in_ready", 32'(rdy_w[0]), 32'b0100);
      @(posedge clk); #1;
      chk("sel2 out_data", data_w[0], 32'hCAFE0002);
      chk("sel2 out_ch", 32'(ch_w[0]), 32'd2);
      sel = 2'd1;
      #1 chk("sel1 in_ready", 32'(rdy_w[0]), 32'd0);
      @(posedge clk); #1;
      chk("sel1 drain", 32'(vld_w[0]), 32'd0);

      // Fixed priority: ch1 wins, ch3 starves
      in_valid = 4'b1010;
      for (int k = 0; k < 3; k++) begin
         #1 chk("prio in_ready", 32'(rdy_w[1]), 32'b0010);
         @(posedge clk); #1;
         chk("prio out_ch", 32'(ch_w[1]), 32'd1);
      end

      // Round-robin from a fresh pointer
      rst_n = 1'b0; in_valid = 4'hF; set_data(32'hCAFE0000);
      @(posedge clk); #1;
      rst_n = 1'b1;
      for (int k = 0; k < 8; k++) begin
         @(posedge clk); #1;
         chk("rr out_valid", 32'(vld_w[2]), 32'd1);
         chk("rr out_ch", 32'(ch_w[2]), 32'(k % 4));
      end
      in_valid = 4'b1001;
      for (int k = 0; k < 4; k++) begin
         @(posedge clk); #1;
         chk("rr wrap out_ch", 32'(ch_w[2]), 32'(alt[k]));
      end

      // Backpressure: held word must not move while inputs churn
      out_ready = 1'b0;
      for (int k = 0; k < 5; k++) begin
         set_data(32'hDEAD0000 + 32'(k << 8));
         #1 chk("bp in_ready", 32'(rdy_w[2]), 32'd0);
         @(posedge clk); #1;
         chk("bp out_valid", 32'(vld_w[2]), 32'd1);
         chk("bp out_data", data_w[2], 32'hCAFE0003);
         chk("bp out_ch", 32'(ch_w[2]), 32'd3);
      end
      set_data(32'h5A5A0000);
      out_ready = 1'b1;
      #1 chk("refill in_ready", 32'(rdy_w[2]), 32'b0001);
      @(posedge clk); #1;
      chk("refill out_data", data_w[2], 32'h5A5A0000);
      chk("refill out_ch", 32'(ch_w[2]), 32'd0);
      @(posedge clk); #1;
      chk("refill next valid", 32'(vld_w[2]), 32'd1);
      chk("refill next data", data_w[2], 32'h5A5A0003);

      // Async reset mid-stream
      rst_n = 1'b0; in_valid = 4'hF;
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      chk("mid g0", 32'(ch_w[2]), 32'd0);
      @(posedge clk); #1;
      chk("mid g1", 32'(ch_w[2]), 32'd1);
      rst_n = 1'b0;
      #1 chk("async drop", 32'(vld_w[2]), 32'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      chk("post rst valid", 32'(vld_w[2]), 32'd1);
      chk("post rst ch", 32'(ch_w[2]), 32'd0);

      repeat (2) @(posedge clk);
      #1;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
